// File: rtl/score_pkg.sv
// Shared types, constants and BCD/segment helpers for the score keeper.
package score_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [3:0] PTS_EASY    = 4'd1;
  localparam logic [3:0] PTS_MED     = 4'd2;
  localparam logic [3:0] PTS_HARD    = 4'd3;
  localparam logic [7:0] BCD_MAX     = 8'h99;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Active-low segments, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [3:0] points(input logic [1:0] mode);
    case (mode)
      2'b01:   return PTS_EASY;
      2'b10:   return PTS_MED;
      2'b11:   return PTS_HARD;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] bcd_add_sat(input logic [7:0] a, input logic [3:0] pts);
    logic [4:0] ones;
    logic [3:0] tens;
    ones = {1'b0, a[3:0]} + {1'b0, pts};
    tens = a[7:4];
    if (ones > 5'd9) begin
      ones = ones - 5'd10;
      tens = tens + 4'd1;
    end
    if (tens > 4'd9) return BCD_MAX;
    return {tens, ones[3:0]};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    if (a[3:0] == 4'd0) return {a[7:4] - 4'd1, 4'd9};
    return {a[7:4], a[3:0] - 4'd1};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ssd_mux.sv
// Four-digit seven-segment multiplexer: rotates anodes 3,2,1,0 every DIV cycles
// and decodes the selected BCD digit; outputs are registered and dark in reset.
module ssd_mux
  import score_pkg::*;
#(
  parameter int DIV = 250
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0][3:0] digits,
  output logic [6:0]      seg,
  output logic [3:0]      an
);

  localparam int RW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [RW-1:0] cnt;
  logic [1:0]    sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel <= 2'd3;
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << sel);
      seg <= seg_decode(digits[sel]);
      if (cnt == RW'(DIV - 1)) begin
        cnt <= '0;
        sel <= sel - 2'd1;
      end else begin
        cnt <= cnt + RW'(1);
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Whack-a-mole score keeper: BCD score, 1 Hz round timer, optional high score
// (enabled by macro HIGH_SCORE_EN) and a 4-digit seven-segment display.
module score_keeper
  import score_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int ROUND_SECONDS = 30,
  parameter int REFRESH_HZ    = 1000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] mode_i,
  input  logic       start_i,
  input  logic       whacked_i,
  output logic [7:0] score_o,
  output logic [7:0] high_score_o,
  output logic       game_over_o,
  output logic [6:0] SSD_seg_o,
  output logic [3:0] SSD_an_o
);

  localparam int TW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int REFRESH_RAW = CLK_FREQ_HZ / (4 * REFRESH_HZ);
  localparam int REFRESH_DIV = (REFRESH_RAW < 1) ? 1 : REFRESH_RAW;
  localparam logic [7:0] ROUND_BCD = {4'(ROUND_SECONDS / 10), 4'(ROUND_SECONDS % 10)};

  // Reset asserts immediately, releases two clocks later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Two sync flops, one history flop, registered edge pulse.
  logic [2:0] start_sh, whack_sh;
  logic       start_p, whack_p;

  always_ff @(posedge clock_i or negedge rst_n) begin
    if (!rst_n) begin
      start_sh <= '0;
      whack_sh <= '0;
      start_p  <= 1'b0;
      whack_p  <= 1'b0;
    end else begin
      start_sh <= {start_sh[1:0], start_i};
      whack_sh <= {whack_sh[1:0], whacked_i};
      start_p  <= start_sh[1] & ~start_sh[2];
      whack_p  <= whack_sh[1] & ~whack_sh[2];
    end
  end

  state_t        state, state_nxt;
  logic [7:0]    timer, timer_nxt, score_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic          tick;

  assign tick = (tick_cnt == TW'(CLK_FREQ_HZ - 1));

  always_ff @(posedge clock_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      score_o  <= 8'h00;
      timer    <= 8'h00;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      score_o  <= score_nxt;
      timer    <= timer_nxt;
      tick_cnt <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    score_nxt = score_o;
    timer_nxt = timer;
    tick_nxt  = tick_cnt;
    case (state)
      PLAY: begin
        if (mode_i == MODE_OFF) begin
          state_nxt = IDLE;
          score_nxt = 8'h00;
        end else begin
          if (whack_p) score_nxt = bcd_add_sat(score_o, points(mode_i));
          if (tick) begin
            tick_nxt  = '0;
            timer_nxt = bcd_dec(timer);
            if (timer == 8'h01) state_nxt = DONE;
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end
      default: begin
        if (start_p && mode_i != MODE_OFF) begin
          state_nxt = PLAY;
          score_nxt = 8'h00;
          timer_nxt = ROUND_BCD;
          tick_nxt  = '0;
        end else if (state == DONE && mode_i == MODE_OFF) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  assign game_over_o = (state == DONE);

  logic [7:0] left;

`ifdef HIGH_SCORE_EN
  logic [7:0] high_score;

  // Compare against score_nxt so a whack landing on the final tick counts.
  always_ff @(posedge clock_i or negedge rst_n) begin
    if (!rst_n) high_score <= 8'h00;
    else if (state == PLAY && state_nxt == DONE && score_nxt > high_score)
      high_score <= score_nxt;
  end

  assign high_score_o = high_score;
  assign left = (state == PLAY) ? timer : high_score;
`else
  assign high_score_o = 8'h00;
  assign left = (state == PLAY) ? timer : {DIGIT_BLANK, DIGIT_BLANK};
`endif

  ssd_mux #(.DIV(REFRESH_DIV)) u_ssd (
    .clk    (clock_i),
    .rst_n  (rst_n),
    .digits ({left, score_o}),
    .seg    (SSD_seg_o),
    .an     (SSD_an_o)
  );

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper (small clock: 1000 Hz, 3 s rounds, 100 Hz refresh).
module tb_score_keeper;

`ifdef HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'h01, S1 = 7'h4F, S2 = 7'h12, S5 = 7'h24, S7 = 7'h0F, SB = 7'h7F;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       start = 1'b0;
  logic       whack = 1'b0;
  logic [7:0] score, hscore;
  logic       go;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int t0 = 0;
  int exp_sc = 0;

  score_keeper #(.CLK_FREQ_HZ(1000), .ROUND_SECONDS(3), .REFRESH_HZ(100)) dut (
    .clock_i(clk), .reset_i(rst), .mode_i(mode), .start_i(start), .whacked_i(whack),
    .score_o(score), .high_score_o(hscore), .game_over_o(go),
    .SSD_seg_o(seg), .SSD_an_o(an)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
    ncyc += n;
  endtask

  task automatic wait_until(input int target);
    while (ncyc < target) cyc(1);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse lands at the 3rd edge; PLAY is entered on the 4th.
  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    t0 = ncyc;
  endtask

  task automatic do_whack();
    whack = 1'b1;
    cyc(2);
    whack = 1'b0;
    cyc(2);
  endtask

  task automatic chk_digit(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (an === an_exp) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL %s_anode: anode %b never seen, last %b", tag, an_exp, an);
    end
    if (found) chk(tag, {1'b0, seg}, {1'b0, seg_exp});
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    // Reset values
    cyc(5);
    chk("rst_score", score, 8'h00);
    chk("rst_hs", hscore, 8'h00);
    chk("rst_go", {7'b0, go}, 8'h00);
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    rst = 1'b1;
    cyc(3);

    // Basic round, mode 01, with whack latency
    mode = 2'b01;
    do_start();
    whack = 1'b1;
    cyc(2);
    whack = 1'b0;
    cyc(1);
    chk("whack_lat3", score, 8'h00);
    cyc(1);
    chk("whack_lat4", score, 8'h01);
    repeat (4) do_whack();
    chk("basic_score", score, 8'h05);
    wait_until(t0 + 2999);
    chk("basic_go_early", {7'b0, go}, 8'h00);
    cyc(1);
    chk("basic_go", {7'b0, go}, 8'h01);
    chk("basic_hs", hscore, HS ? 8'h05 : 8'h00);
    chk("basic_hold", score, 8'h05);

    // Abort mid-PLAY, then IDLE display
    do_start();
    repeat (2) do_whack();
    chk("abort_pre", score, 8'h02);
    mode = 2'b00;
    cyc(1);
    chk("abort_score", score, 8'h00);
    chk("abort_go", {7'b0, go}, 8'h00);
    chk("abort_hs", hscore, HS ? 8'h05 : 8'h00);
    chk_digit("idle_d3", 4'b0111, HS ? S0 : SB);
    chk_digit("idle_d2", 4'b1011, HS ? S5 : SB);
    chk_digit("idle_d1", 4'b1101, S0);
    chk_digit("idle_d0", 4'b1110, S0);

    // Lower-score round leaves the high score alone
    mode = 2'b01;
    do_start();
    do_whack();
    wait_until(t0 + 3000);
    chk("low_go", {7'b0, go}, 8'h01);
    chk("low_score", score, 8'h01);
    chk("low_hs", hscore, HS ? 8'h05 : 8'h00);

    // Saturation, 3 points per whack
    mode = 2'b11;
    do_start();
    exp_sc = 0;
    for (int i = 0; i < 34; i++) begin
      do_whack();
      exp_sc = (exp_sc + 3 > 99) ? 99 : exp_sc + 3;
      chk((i == 3) ? "bcd_09_12" : "sat", score, to_bcd(exp_sc));
    end
    mode = 2'b00;
    cyc(1);
    chk("sat_abort", score, 8'h00);

    // Display in PLAY, ignored start, whack on the final tick
    mode = 2'b01;
    do_start();
    repeat (17) do_whack();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    chk("play_start_ign", score, 8'h17);
    wait_until(t0 + 1100);
    chk_digit("play_d3", 4'b0111, S0);
    chk_digit("play_d2", 4'b1011, S2);
    chk_digit("play_d1", 4'b1101, S1);
    chk_digit("play_d0", 4'b1110, S7);
    wait_until(t0 + 2996);
    whack = 1'b1;
    cyc(2);
    whack = 1'b0;
    cyc(1);
    chk("edge_pre_score", score, 8'h17);
    chk("edge_pre_go", {7'b0, go}, 8'h00);
    cyc(1);
    chk("edge_score", score, 8'h18);
    chk("edge_go", {7'b0, go}, 8'h01);
    chk("edge_hs", hscore, HS ? 8'h18 : 8'h00);

    // Asynchronous reset mid-PLAY
    do_start();
    do_whack();
    chk("ar_pre", score, 8'h01);
    #3 rst = 1'b0;
    #1;
    chk("ar_score", score, 8'h00);
    chk("ar_hs", hscore, 8'h00);
    chk("ar_go", {7'b0, go}, 8'h00);
    chk("ar_an", {4'h0, an}, 8'h0F);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mode = 2'b00;
    cyc(3);
    chk("ar_after", score, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
